// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one uart_tx between NUM_REQ byte producers.
// Optional grant retention via req_lock_in when UART_TX_ARB_LOCK_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  input  logic [8*NUM_REQ-1:0]       req_byte_in,
  input  logic [NUM_REQ-1:0]         req_lock_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  output logic                       tx_start_out,
  output logic [7:0]                 tx_byte_out,
  input  logic                       tx_done_in,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_out,
  output logic                       busy_out
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  logic [1:0]    state;
  logic          win_found;
  logic [IW-1:0] win_id;
  logic          accept;

`ifndef UART_TX_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^req_lock_in;
`endif

  // Descending scan so the nearest requester after the pointer wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = grant_id_out;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid_in[(int'(grant_id_out) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_id    = IW'((int'(grant_id_out) + k) % NUM_REQ);
      end
    end
`ifdef UART_TX_ARB_LOCK_EN
    if (req_lock_in[grant_id_out]) begin
      win_found = req_valid_in[grant_id_out];
      win_id    = grant_id_out;
    end
`endif
  end

  assign accept = rst_n && (state == IDLE) && win_found;

  always_comb begin
    req_ready_out = '0;
    if (accept) req_ready_out[win_id] = 1'b1;
  end

  assign tx_start_out = (state == START);
  assign busy_out     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tx_byte_out  <= 8'h00;
      grant_id_out <= IW'(NUM_REQ - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            tx_byte_out  <= req_byte_in[int'(win_id)*8 +: 8];
            grant_id_out <= win_id;
            state        <= START;
          end
        end
        START:     state <= WAIT_DONE;
        WAIT_DONE: if (tx_done_in) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=2)
// with a small behavioural uart_tx model, CLKS_PER_BIT=4.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [15:0] req_byte;
  logic [1:0] req_lock;
  logic [1:0] req_ready;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_done;
  logic       grant_id;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // uart_tx model
  logic       act;
  logic [8:0] sh;
  logic [1:0] cnt;
  logic [3:0] bitn;
  logic       line;
  logic       mdl_done;
  logic       inj_done;

  assign tx_done = mdl_done | inj_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_in (req_valid),
    .req_byte_in  (req_byte),
    .req_lock_in  (req_lock),
    .req_ready_out(req_ready),
    .tx_start_out (tx_start),
    .tx_byte_out  (tx_byte),
    .tx_done_in   (tx_done),
    .grant_id_out (grant_id),
    .busy_out     (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act      <= 1'b0;
      sh       <= '0;
      cnt      <= '0;
      bitn     <= '0;
      line     <= 1'b1;
      mdl_done <= 1'b0;
    end else begin
      mdl_done <= 1'b0;
      if (!act) begin
        if (tx_start) begin
          act  <= 1'b1;
          line <= 1'b0;
          sh   <= {1'b1, tx_byte};
          cnt  <= '0;
          bitn <= '0;
        end
      end else if (cnt == 2'd3) begin
        cnt <= '0;
        if (bitn == 4'd9) begin
          act      <= 1'b0;
          mdl_done <= 1'b1;
        end else begin
          line <= sh[0];
          sh   <= sh >> 1;
          bitn <= bitn + 4'd1;
        end
      end else begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_byte  = '0;
    req_lock  = '0;
    inj_done  = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready == 2'b00 && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (req_ready == 2'b00) begin
      errors++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required nonzero", req_ready, n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({req_ready, tx_start, tx_byte, grant_id, busy} !== {2'b00, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset: ready=%b start=%b byte=%h gid=%b busy=%b, required 00 0 00 1 0",
               req_ready, tx_start, tx_byte, grant_id, busy);
    end
  endtask

  task automatic test_single();
    logic [9:0] bits;
    req_byte[7:0] = 8'h55;
    req_valid     = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: ready=%b busy=%b, required 01 0", req_ready, busy);
    end
    tick(1);
    req_valid = 2'b00;
    #1;
    checks++;
    if ({tx_start, tx_byte, grant_id, busy, req_ready} !== {1'b1, 8'h55, 1'b0, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL single_start: start=%b byte=%h gid=%b busy=%b ready=%b, required 1 55 0 1 00",
               tx_start, tx_byte, grant_id, busy, req_ready);
    end
    tick(1);
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL single_one_pulse: start=%b, required 0", tx_start);
    end
    tick(1);
    for (int i = 0; i < 10; i++) begin
      bits[i] = line;
      if (i < 9) tick(4);
    end
    checks++;
    if (bits !== 10'b1010101010) begin
      errors++;
      $display("FAIL single_line: bits(lsb first)=%b, required 1010101010", bits);
    end
    wait_idle();
    checks++;
    if (tx_byte !== 8'h55) begin
      errors++;
      $display("FAIL single_hold: byte=%h, required 55", tx_byte);
    end
  endtask

  task automatic test_contention();
    logic [9:0] bits;
    logic [7:0] exp_b;
    logic       got;
    apply_reset();
    req_byte  = {8'hB1, 8'hA0};
    req_valid = 2'b11;
    #1;
    for (int f = 0; f < 4; f++) begin
      exp_b = (f % 2 == 0) ? 8'hA0 : 8'hB1;
      wait_ready();
      got = req_ready[1];
      checks++;
      if (req_ready !== ((f % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL contention_grant%0d: ready=%b, required requester %0d", f, req_ready, f % 2);
      end
      tick(1);
      checks++;
      if (tx_byte !== exp_b || grant_id !== got) begin
        errors++;
        $display("FAIL contention_byte%0d: byte=%h gid=%b, required %h", f, tx_byte, grant_id, exp_b);
      end
      tick(2);
      for (int i = 0; i < 10; i++) begin
        bits[i] = line;
        if (i < 9) tick(4);
      end
      checks++;
      if (bits !== {1'b1, exp_b, 1'b0}) begin
        errors++;
        $display("FAIL contention_line%0d: bits=%b, required %b", f, bits, {1'b1, exp_b, 1'b0});
      end
    end
    req_valid = 2'b00;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    req_byte[7:0] = 8'h11;
    req_valid     = 2'b01;
    tick(2);
    while (tx_done !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (tx_done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: done=%b busy=%b, required 1 1", tx_done, busy);
    end
    tick(1);
    checks++;
    if (busy !== 1'b0 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b ready=%b, required 0 01", busy, req_ready);
    end
    tick(1);
    req_valid = 2'b00;
    #1;
    checks++;
    if (tx_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: start=%b, required 1", tx_start);
    end
    wait_idle();
  endtask

  task automatic test_spurious_done();
    inj_done = 1'b1;
    tick(1);
    inj_done = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy, req_ready, tx_start} !== 4'b0000) begin
        errors++;
        $display("FAIL spurious_done%0d: busy=%b ready=%b start=%b, required 0 00 0",
                 i, busy, req_ready, tx_start);
      end
      tick(1);
    end
  endtask

  task automatic test_reset_mid_frame();
    req_byte[7:0] = 8'h77;
    req_valid     = 2'b01;
    tick(1);
    req_valid = 2'b00;
    tick(3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy: busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, tx_start, tx_byte, grant_id, busy} !== {2'b00, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midreset_outputs: ready=%b start=%b byte=%h gid=%b busy=%b, required 00 0 00 1 0",
               req_ready, tx_start, tx_byte, grant_id, busy);
    end
    tick(1);
    req_byte  = {8'h3C, 8'h00};
    req_valid = 2'b10;
    rst_n     = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL midreset_regrant: ready=%b, required 10", req_ready);
    end
    tick(1);
    req_valid = 2'b00;
    checks++;
    if (tx_byte !== 8'h3C || grant_id !== 1'b1) begin
      errors++;
      $display("FAIL midreset_byte: byte=%h gid=%b, required 3c 1", tx_byte, grant_id);
    end
    wait_idle();
  endtask

  task automatic test_lock();
    logic [1:0] exp_r [4];
`ifdef UART_TX_ARB_LOCK_EN
    exp_r = '{2'b10, 2'b10, 2'b10, 2'b01};
`else
    exp_r = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    apply_reset();
    req_byte  = {8'hD2, 8'hC1};
    req_lock  = 2'b10;
    req_valid = 2'b11;
    #1;
    for (int f = 0; f < 4; f++) begin
      wait_ready();
      checks++;
      if (req_ready !== exp_r[f]) begin
        errors++;
        $display("FAIL lock_grant%0d: ready=%b, required %b", f, req_ready, exp_r[f]);
      end
      tick(1);
      if (f == 2) req_lock = 2'b00;
    end
    req_valid = 2'b00;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_spurious_done();
    test_reset_mid_frame();
    test_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
